// File: rtl/vjtag_debug_pkg.sv
// Shared types and constants for the virtual-JTAG debug scan master.
package vjtag_debug_pkg;

    localparam int unsigned SR_WIDTH_DEFAULT = 38;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        UIR,
        CDR,
        SHIFT,
        UDR,
        RTI,
        DONE
    } scan_state_t;

endpackage

// File: rtl/vjtag_tck_gen.sv
// Test-clock divider: tck low for the first TCK_DIV clk cycles of a period, high for the rest.
module vjtag_tck_gen #(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tck,
    output logic rise,
    output logic period_end
);
    localparam int unsigned PERIOD = 2 * TCK_DIV;
    localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] HALF    = CW'(TCK_DIV);
    localparam logic [CW-1:0] RISE_AT = CW'(TCK_DIV - 1);
    localparam logic [CW-1:0] LAST    = CW'(PERIOD - 1);

    logic [CW-1:0] cnt;

    // Counter parks at zero while disabled so every enabled stretch starts on a period boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!en || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tck        = (cnt >= HALF);
    // rise marks the clk cycle whose closing edge raises tck
    assign rise       = en && (cnt == RISE_AT);
    assign period_end = en && (cnt == LAST);

endmodule

// File: rtl/vjtag_debug_scan_master.sv
// Initiator for the Nios II debug-slave virtual-JTAG link: plays UIR/CDR/SDR/UDR/RTI per command.
module vjtag_debug_scan_master
    import vjtag_debug_pkg::*;
#(
    parameter int unsigned SR_WIDTH   = SR_WIDTH_DEFAULT,
    parameter int unsigned IR_WIDTH   = 2,
    parameter int unsigned TCK_DIV    = 2,
    parameter int unsigned RTI_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);
    localparam int unsigned BW = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;
    localparam int unsigned RW = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(SR_WIDTH - 1);
    localparam logic [RW-1:0] RTI_LAST = RW'(RTI_CYCLES - 1);

    scan_state_t         state, state_d;
    logic [SR_WIDTH-1:0] data_q;
    logic [SR_WIDTH-1:0] rsp_q;
    logic [IR_WIDTH-1:0] ir_q;
    logic [BW-1:0]       bit_cnt;
    logic [RW-1:0]       rti_cnt;
    logic                tck_en;
    logic                tck_rise;
    logic                period_end;
    logic                accept;

    vjtag_tck_gen #(
        .TCK_DIV(TCK_DIV)
    ) u_tck_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (tck_en),
        .tck       (vji_tck),
        .rise      (tck_rise),
        .period_end(period_end)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        tck_en    = 1'b0;
        accept    = 1'b0;
        vji_tdi   = 1'b0;
        vji_uir   = 1'b0;
        vji_cdr   = 1'b0;
        vji_sdr   = 1'b0;
        vji_udr   = 1'b0;
        vji_rti   = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = UIR;
                end
            end
            UIR: begin
                vji_uir = 1'b1;
                tck_en  = 1'b1;
                if (period_end) state_d = CDR;
            end
            CDR: begin
                vji_cdr = 1'b1;
                tck_en  = 1'b1;
                if (period_end) state_d = SHIFT;
            end
            SHIFT: begin
                vji_sdr = 1'b1;
                tck_en  = 1'b1;
                vji_tdi = data_q[bit_cnt];
                if (period_end && bit_cnt == BIT_LAST) state_d = UDR;
            end
            UDR: begin
                vji_udr = 1'b1;
                tck_en  = 1'b1;
                if (period_end) state_d = RTI;
            end
            RTI: begin
                vji_rti = 1'b1;
                tck_en  = 1'b1;
                if (period_end && rti_cnt == RTI_LAST) state_d = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // IR is latched on the accept edge, which is also the start of UIR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            rsp_q   <= '0;
            ir_q    <= '0;
            bit_cnt <= '0;
            rti_cnt <= '0;
        end else begin
            if (accept) begin
                data_q  <= cmd_data;
                ir_q    <= cmd_ir;
                bit_cnt <= '0;
                rti_cnt <= '0;
            end
            if (state == SHIFT && tck_rise) begin
                rsp_q[bit_cnt] <= vji_tdo;
            end
            if (state == SHIFT && period_end && bit_cnt != BIT_LAST) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == RTI && period_end && rti_cnt != RTI_LAST) begin
                rti_cnt <= rti_cnt + 1'b1;
            end
        end
    end

    assign vji_ir_in = ir_q;
    assign rsp_data  = rsp_q;

endmodule

// File: tb/tb_vjtag_debug_scan_master.sv
// Directed bench: two scan-master instances (default timing and TCK_DIV=1/RTI_CYCLES=1) against shift-register slave models.
module tb_vjtag_debug_scan_master;
    import vjtag_debug_pkg::*;

    localparam int unsigned W = 38;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   tests = 0;
    int   fails = 0;

    // instance A: default timing
    logic         a_cmd_valid, a_cmd_ready, a_rsp_valid, a_rsp_ready;
    logic [1:0]   a_cmd_ir, a_ir_in;
    logic [W-1:0] a_cmd_data, a_rsp_data;
    logic         a_tck, a_tdi, a_tdo, a_uir, a_cdr, a_sdr, a_udr, a_rti;

    // instance B: fast timing
    logic         b_cmd_valid, b_cmd_ready, b_rsp_valid, b_rsp_ready;
    logic [1:0]   b_cmd_ir, b_ir_in;
    logic [W-1:0] b_cmd_data, b_rsp_data;
    logic         b_tck, b_tdi, b_tdo, b_uir, b_cdr, b_sdr, b_udr, b_rti;

    vjtag_debug_scan_master #(
        .SR_WIDTH(W), .IR_WIDTH(2), .TCK_DIV(2), .RTI_CYCLES(2)
    ) dut_a (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_ir(a_cmd_ir), .cmd_data(a_cmd_data),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
        .vji_tck(a_tck), .vji_tdi(a_tdi), .vji_tdo(a_tdo), .vji_ir_in(a_ir_in),
        .vji_uir(a_uir), .vji_cdr(a_cdr), .vji_sdr(a_sdr), .vji_udr(a_udr), .vji_rti(a_rti)
    );

    vjtag_debug_scan_master #(
        .SR_WIDTH(W), .IR_WIDTH(2), .TCK_DIV(1), .RTI_CYCLES(1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_ir(b_cmd_ir), .cmd_data(b_cmd_data),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
        .vji_tck(b_tck), .vji_tdi(b_tdi), .vji_tdo(b_tdo), .vji_ir_in(b_ir_in),
        .vji_uir(b_uir), .vji_cdr(b_cdr), .vji_sdr(b_sdr), .vji_udr(b_udr), .vji_rti(b_rti)
    );

    // Slave models: LSB-first shift register, tdi enters at the top on tck rise during SDR.
    logic [W-1:0] a_sr, a_preload, b_sr, b_preload;
    logic         a_load = 1'b0;
    logic         b_load = 1'b0;

    always @(posedge a_tck or posedge a_load)
        if (a_load) a_sr <= a_preload;
        else if (a_sdr) a_sr <= {a_tdi, a_sr[W-1:1]};
    assign a_tdo = a_sr[0];

    always @(posedge b_tck or posedge b_load)
        if (b_load) b_sr <= b_preload;
        else if (b_sdr) b_sr <= {b_tdi, b_sr[W-1:1]};
    assign b_tdo = b_sr[0];

    // Strobe and tck monitor for instance A.
    logic        mon_clr = 1'b1;
    logic        tck_prev;
    int unsigned n_uir, n_cdr, n_sdr, n_udr, n_rti, n_overlap, n_rise;

    always @(negedge clk) begin
        if (mon_clr) begin
            n_uir <= 0; n_cdr <= 0; n_sdr <= 0; n_udr <= 0; n_rti <= 0;
            n_overlap <= 0; n_rise <= 0; tck_prev <= 1'b0;
        end else begin
            n_uir <= n_uir + 32'(a_uir);
            n_cdr <= n_cdr + 32'(a_cdr);
            n_sdr <= n_sdr + 32'(a_sdr);
            n_udr <= n_udr + 32'(a_udr);
            n_rti <= n_rti + 32'(a_rti);
            if (32'(a_uir) + 32'(a_cdr) + 32'(a_sdr) + 32'(a_udr) + 32'(a_rti) > 1)
                n_overlap <= n_overlap + 1;
            if (a_tck && !tck_prev) n_rise <= n_rise + 1;
            tck_prev <= a_tck;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [W-1:0] v);
        a_preload = v;
        a_load = 1'b1;
        #1;
        a_load = 1'b0;
    endtask

    task automatic accept_a(input logic [1:0] ir, input logic [W-1:0] data, input bit keep);
        a_cmd_ir    = ir;
        a_cmd_data  = data;
        a_cmd_valid = 1'b1;
        tick();
        if (!keep) a_cmd_valid = 1'b0;
    endtask

    // lat counts the accept cycle as 1 and is called right after the accept edge.
    task automatic wait_rsp_a(output int lat);
        lat = 1;
        while (!a_rsp_valid && lat < 1000) begin
            tick();
            lat++;
        end
    endtask

    task automatic retire_a();
        a_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;
    endtask

    int lat;

    initial begin
        reset_n = 1'b0;
        a_cmd_valid = 1'b0; a_cmd_ir = '0; a_cmd_data = '0; a_rsp_ready = 1'b0;
        b_cmd_valid = 1'b0; b_cmd_ir = '0; b_cmd_data = '0; b_rsp_ready = 1'b0;
        a_preload = '0; b_preload = '0;
        #1;
        load_a('0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        chk("rst_cmd_ready", 64'(a_cmd_ready), 64'd1);
        chk("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(a_rsp_data), 64'd0);
        chk("rst_vji", 64'({a_tck, a_tdi, a_uir, a_cdr, a_sdr, a_udr, a_rti}), 64'd0);
        chk("rst_ir_in", 64'(a_ir_in), 64'd0);

        // Scan 1: BREAK with alternating patterns, full strobe audit.
        load_a(38'h15_AAAA_AAAA);
        mon_clr = 1'b1;
        tick();
        mon_clr = 1'b0;
        accept_a(IR_BREAK, 38'h2A_5555_5555, 1'b0);
        chk("s1_cmd_ready_after_accept", 64'(a_cmd_ready), 64'd0);
        chk("s1_uir_first", 64'(a_uir), 64'd1);
        wait_rsp_a(lat);
        chk("s1_latency", 64'(lat), 64'd173);
        chk("s1_rsp_data", 64'(a_rsp_data), 64'(38'h15_AAAA_AAAA));
        chk("s1_slave_holds", 64'(a_sr), 64'(38'h2A_5555_5555));
        chk("s1_ir_in", 64'(a_ir_in), 64'd2);
        chk("s1_done_cmd_ready", 64'(a_cmd_ready), 64'd0);
        chk("s1_done_vji", 64'({a_tck, a_uir, a_cdr, a_sdr, a_udr, a_rti}), 64'd0);
        chk("s1_n_uir", 64'(n_uir), 64'd4);
        chk("s1_n_cdr", 64'(n_cdr), 64'd4);
        chk("s1_n_sdr", 64'(n_sdr), 64'd152);
        chk("s1_n_udr", 64'(n_udr), 64'd4);
        chk("s1_n_rti", 64'(n_rti), 64'd8);
        chk("s1_overlap", 64'(n_overlap), 64'd0);
        chk("s1_tck_rises", 64'(n_rise), 64'd43);
        retire_a();
        chk("s1_retired_rsp_valid", 64'(a_rsp_valid), 64'd0);
        chk("s1_idle_cmd_ready", 64'(a_cmd_ready), 64'd1);

        // IR tracking: OCIMEM then TRACECTRL.
        load_a(38'h3F_0F0F_0F0F);
        accept_a(IR_OCIMEM, 38'h00_1234_5678, 1'b0);
        chk("ir0_at_uir", 64'(a_ir_in), 64'd0);
        wait_rsp_a(lat);
        chk("ir0_rsp_data", 64'(a_rsp_data), 64'(38'h3F_0F0F_0F0F));
        chk("ir0_held_done", 64'(a_ir_in), 64'd0);
        retire_a();
        repeat (3) tick();
        chk("ir0_held_idle", 64'(a_ir_in), 64'd0);
        a_cmd_ir = IR_TRACECTRL;
        #1;
        chk("ir0_before_accept", 64'(a_ir_in), 64'd0);
        accept_a(IR_TRACECTRL, 38'h25_A5A5_0FF0, 1'b0);
        chk("ir3_at_uir", 64'(a_ir_in), 64'd3);
        wait_rsp_a(lat);
        chk("ir3_rsp_data", 64'(a_rsp_data), 64'(38'h00_1234_5678));
        retire_a();
        repeat (3) tick();
        chk("ir3_held_idle", 64'(a_ir_in), 64'd3);

        // Backpressure with cmd_valid held high throughout.
        accept_a(IR_TRACEMEM, 38'h1C_DEAD_BEEF, 1'b1);
        wait_rsp_a(lat);
        chk("bp_latency", 64'(lat), 64'd173);
        chk("bp_rsp_data", 64'(a_rsp_data), 64'(38'h25_A5A5_0FF0));
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_hold_valid", 64'(a_rsp_valid), 64'd1);
            chk("bp_hold_data", 64'(a_rsp_data), 64'(38'h25_A5A5_0FF0));
            chk("bp_hold_cmd_ready", 64'(a_cmd_ready), 64'd0);
        end
        a_cmd_ir = IR_BREAK;
        a_cmd_data = 38'h0B_1357_9BDF;
        a_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;
        chk("bp_idle_cmd_ready", 64'(a_cmd_ready), 64'd1);
        chk("bp_idle_rsp_valid", 64'(a_rsp_valid), 64'd0);
        chk("bp_idle_no_uir", 64'(a_uir), 64'd0);
        tick();
        a_cmd_valid = 1'b0;
        chk("bp_second_accepted", 64'(a_cmd_ready), 64'd0);
        chk("bp_second_uir", 64'(a_uir), 64'd1);
        chk("bp_second_ir", 64'(a_ir_in), 64'd2);
        wait_rsp_a(lat);
        chk("bp_second_latency", 64'(lat), 64'd173);
        chk("bp_second_rsp_data", 64'(a_rsp_data), 64'(38'h1C_DEAD_BEEF));
        retire_a();

        // Asynchronous reset in the tck-high half of shift bit 17 (cycles 79..80 after accept).
        load_a(38'h2B_CAFE_F00D);
        accept_a(IR_OCIMEM, 38'h11_2233_4455, 1'b0);
        repeat (78) tick();
        chk("rst_mid_sdr", 64'(a_sdr), 64'd1);
        chk("rst_mid_tck", 64'(a_tck), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_vji", 64'({a_tck, a_tdi, a_uir, a_cdr, a_sdr, a_udr, a_rti}), 64'd0);
        chk("rst_async_ir_in", 64'(a_ir_in), 64'd0);
        chk("rst_async_cmd_ready", 64'(a_cmd_ready), 64'd1);
        chk("rst_async_rsp_valid", 64'(a_rsp_valid), 64'd0);
        chk("rst_async_rsp_data", 64'(a_rsp_data), 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("rst_after_rsp_valid", 64'(a_rsp_valid), 64'd0);
        chk("rst_after_cmd_ready", 64'(a_cmd_ready), 64'd1);
        load_a(38'h2B_CAFE_F00D);
        accept_a(IR_TRACECTRL, 38'h05_0505_0505, 1'b0);
        wait_rsp_a(lat);
        chk("rst_rescan_latency", 64'(lat), 64'd173);
        chk("rst_rescan_rsp_data", 64'(a_rsp_data), 64'(38'h2B_CAFE_F00D));
        chk("rst_rescan_slave", 64'(a_sr), 64'(38'h05_0505_0505));
        retire_a();

        // Instance B: TCK_DIV=1, RTI_CYCLES=1.
        b_preload = 38'h3A_C3C3_C3C3;
        b_load = 1'b1;
        #1;
        b_load = 1'b0;
        b_cmd_ir = IR_TRACEMEM;
        b_cmd_data = 38'h05_F00F_7117;
        b_cmd_valid = 1'b1;
        tick();
        b_cmd_valid = 1'b0;
        lat = 1;
        chk("b_tck_low_phase", 64'(b_tck), 64'd0);
        tick();
        lat++;
        chk("b_tck_high_phase", 64'(b_tck), 64'd1);
        while (!b_rsp_valid && lat < 1000) begin
            tick();
            lat++;
        end
        chk("b_latency", 64'(lat), 64'd85);
        chk("b_rsp_data", 64'(b_rsp_data), 64'(38'h3A_C3C3_C3C3));
        chk("b_slave_holds", 64'(b_sr), 64'(38'h05_F00F_7117));
        chk("b_ir_in", 64'(b_ir_in), 64'd1);
        b_rsp_ready = 1'b1;
        tick();
        b_rsp_ready = 1'b0;
        chk("b_retired", 64'({b_rsp_valid, b_cmd_ready}), 64'b01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
